muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit in the execute stage. It sits beside the single-cycle ALU and accepts an operation when the decoded instruction is OP with func7 = 0000001. It holds the pipeline with `busy` while it computes, then returns the 32-bit result with a one-cycle `done` pulse. Multiplies use a registered single-cycle product; divides and remainders use a 32-iteration restoring divider with sign fix-up.

---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_unit_div_iter.sv | 24 ++
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants, request payload and helpers for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned CNT_W  = 6;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    localparam logic [2:0] MD_S_IDLE = 3'd0;
    localparam logic [2:0] MD_S_MUL  = 3'd1;
    localparam logic [2:0] MD_S_DIV  = 3'd2;
    localparam logic [2:0] MD_S_FIX  = 3'd3;
    localparam logic [2:0] MD_S_DONE = 3'd4;

    typedef struct packed {
        logic [2:0]        func3;
        logic [XLEN_W-1:0] op_a;
        logic [XLEN_W-1:0] op_b;
    } md_req_t;

    // Magnitude of v when treated as signed (sgn=1), raw value otherwise.
    function automatic logic [XLEN_W-1:0] mag(input logic [XLEN_W-1:0] v, input logic sgn);
        return (sgn && v[XLEN_W-1]) ? XLEN_W'(~v + XLEN_W'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One combinational restoring-division step: shift in next dividend bit, trial subtract.
module div_iter
    import muldiv_unit_pkg::*;
(
    input  logic [XLEN_W:0]   rem,
    input  logic [XLEN_W-1:0] quo,
    input  logic [XLEN_W-1:0] divisor,
    output logic [XLEN_W:0]   rem_next_c,
    output logic [XLEN_W-1:0] quo_next_c
);

    logic [XLEN_W+1:0] shifted;
    logic [XLEN_W+1:0] diff;
    logic              ge;

    always_comb begin
        shifted    = {rem, quo[XLEN_W-1]};
        diff       = shifted - {2'b00, divisor};
        ge         = ~diff[XLEN_W+1];
        rem_next_c = ge ? diff[XLEN_W:0] : shifted[XLEN_W:0];
        quo_next_c = {quo[XLEN_W-2:0], ge};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit; MULDIV_EARLY_OUT_EN enables single-cycle divide-by-zero/overflow results.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [2:0]        state_q,  state_nxt;
    logic [CNT_W-1:0]  cnt_q,    cnt_nxt;
    md_req_t           req_q,    req_nxt;
    logic [XLEN_W-1:0] dvs_q,    dvs_nxt;
    logic [XLEN_W:0]   rem_q,    rem_nxt;
    logic [XLEN_W-1:0] quo_q,    quo_nxt;
    logic [XLEN_W-1:0] result_nxt;
    logic              busy_nxt, done_nxt;

    logic [XLEN_W:0]   rem_step_c;
    logic [XLEN_W-1:0] quo_step_c;

    logic              sgn_a, sgn_b, sgn_div;
    logic [63:0]       a_ext, b_ext, prod;
    logic [XLEN_W-1:0] mul_res, q_fix, r_fix, div_res;

    div_iter u_div_iter (
        .rem        (rem_q),
        .quo        (quo_q),
        .divisor    (dvs_q),
        .rem_next_c (rem_step_c),
        .quo_next_c (quo_step_c)
    );

    // Product with per-op signedness via sign extension to 64 bits.
    always_comb begin
        sgn_a   = (req_q.func3[1:0] == 2'b01) || (req_q.func3[1:0] == 2'b10);
        sgn_b   = (req_q.func3[1:0] == 2'b01);
        a_ext   = {{32{sgn_a & req_q.op_a[31]}}, req_q.op_a};
        b_ext   = {{32{sgn_b & req_q.op_b[31]}}, req_q.op_b};
        prod    = a_ext * b_ext;
        mul_res = (req_q.func3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end

    // Sign fix-up and divide-by-zero override of the unsigned divider outputs.
    always_comb begin
        sgn_div = ~req_q.func3[0];
        q_fix   = (sgn_div && (req_q.op_a[31] ^ req_q.op_b[31])) ? XLEN_W'(~quo_q + 32'd1) : quo_q;
        r_fix   = (sgn_div && req_q.op_a[31]) ? XLEN_W'(~rem_q[31:0] + 32'd1) : rem_q[31:0];
        if (req_q.op_b == '0) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = req_q.op_a;
        end
        div_res = req_q.func3[1] ? r_fix : q_fix;
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        req_nxt    = req_q;
        dvs_nxt    = dvs_q;
        rem_nxt    = rem_q;
        quo_nxt    = quo_q;
        result_nxt = result;

        case (state_q)
            MD_S_IDLE: begin
                if (start) begin
                    req_nxt = '{func3: func3, op_a: op_a, op_b: op_b};
                    if (!func3[2]) begin
                        state_nxt = MD_S_MUL;
                    end else begin
                        dvs_nxt   = mag(op_b, ~func3[0]);
                        quo_nxt   = mag(op_a, ~func3[0]);
                        rem_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = MD_S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
                        if (op_b == '0) begin
                            result_nxt = func3[1] ? op_a : 32'hFFFF_FFFF;
                            state_nxt  = MD_S_DONE;
                        end else if (!func3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                            result_nxt = func3[1] ? 32'h0 : 32'h8000_0000;
                            state_nxt  = MD_S_DONE;
                        end
`endif
                    end
                end
            end
            MD_S_MUL: begin
                result_nxt = mul_res;
                state_nxt  = MD_S_DONE;
            end
            MD_S_DIV: begin
                rem_nxt = rem_step_c;
                quo_nxt = quo_step_c;
                cnt_nxt = CNT_W'(cnt_q + 6'd1);
                if (cnt_q == 6'd31) begin
                    state_nxt = MD_S_FIX;
                end
            end
            MD_S_FIX: begin
                result_nxt = div_res;
                state_nxt  = MD_S_DONE;
            end
            MD_S_DONE: begin
                state_nxt = MD_S_IDLE;
            end
            default: begin
                state_nxt = MD_S_IDLE;
            end
        endcase

        // Flush wins over everything, including a same-cycle start.
        if (kill) begin
            state_nxt  = MD_S_IDLE;
            result_nxt = result;
        end

        busy_nxt = (state_nxt == MD_S_MUL) || (state_nxt == MD_S_DIV) || (state_nxt == MD_S_FIX);
        done_nxt = (state_nxt == MD_S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            req_q   <= req_nxt;
            dvs_q   <= dvs_nxt;
            rem_q   <= rem_nxt;
            quo_q   <= quo_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            result  <= result_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; latency expectations follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int   EO_LAT  = 1;
    localparam logic EO_BUSY = 1'b0;
`else
    localparam int   EO_LAT  = 34;
    localparam logic EO_BUSY = 1'b1;
`endif

    logic        clk, rst_n, start, kill;
    logic [2:0]  func3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int vectors    = 0;
    int miscompares = 0;

    int          lat;
    logic [31:0] res;
    logic        b1, bk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op at the next edge (cycle 0) and follow it for up to 60 cycles.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int poke_c, input int kill_c,
                          output int lt, output logic [31:0] rs, output logic bs1, output logic bsk);
        func3 = f; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lt = -1; rs = 32'hDEAD_BEEF; bs1 = 1'bx; bsk = 1'bx;
        for (int c = 1; c <= 60; c++) begin
            if (c == 1) bs1 = busy;
            if (c == kill_c + 1) bsk = busy;
            if (done) begin
                lt = c; rs = result;
                break;
            end
            start = (c == poke_c);
            kill  = (c == kill_c);
            if (c == poke_c) begin
                func3 = MD_MUL; op_a = 32'd2; op_b = 32'd3;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; kill = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0;
        func3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_done",   32'(done),   32'h0);
        check("rst_result", result,      32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, res, b1, bk);
        check("mulh_res",  res,         32'h0000_0000);
        check("mulh_lat",  32'(lat),    32'd2);
        check("mulh_busy", 32'(b1),     32'h1);
        run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, res, b1, bk);
        check("mulhu_res", res,         32'hFFFF_FFFE);
        check("mulhu_lat", 32'(lat),    32'd2);
        run_op(MD_MUL, 32'hFFFF_FFFF, 32'd2, 0, 0, lat, res, b1, bk);
        check("mul_res",   res,         32'hFFFF_FFFE);
        run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 0, 0, lat, res, b1, bk);
        check("mulhsu_res", res,        32'hFFFF_FFFF);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, res, b1, bk);
        check("div_res",   res,         32'hFFFF_FFFD);
        check("div_lat",   32'(lat),    32'd34);
        run_op(MD_REM, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, res, b1, bk);
        check("rem_res",   res,         32'hFFFF_FFFF);
        check("rem_lat",   32'(lat),    32'd34);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, res, b1, bk);
        check("div_ovf_res", res,       32'h8000_0000);
        run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, res, b1, bk);
        check("rem_ovf_res", res,       32'h0000_0000);

        run_op(MD_DIVU, 32'd100, 32'd0, 0, 0, lat, res, b1, bk);
        check("divu_z_res",  res,       32'hFFFF_FFFF);
        check("divu_z_lat",  32'(lat),  32'(EO_LAT));
        check("divu_z_busy", 32'(b1),   32'(EO_BUSY));
        run_op(MD_REMU, 32'd100, 32'd0, 0, 0, lat, res, b1, bk);
        check("remu_z_res",  res,       32'd100);
        check("remu_z_lat",  32'(lat),  32'(EO_LAT));

        // Kill in cycle 10 of a divide: no done, result keeps 100.
        run_op(MD_DIV, 32'd100, 32'd7, 0, 10, lat, res, b1, bk);
        check("kill_no_done", 32'(lat), 32'hFFFF_FFFF);
        check("kill_busy11",  32'(bk),  32'h0);
        check("kill_result",  result,   32'd100);
        run_op(MD_MUL, 32'd6, 32'd7, 0, 0, lat, res, b1, bk);
        check("mul67_res",  res,        32'd42);
        check("mul67_lat",  32'(lat),   32'd2);

        // A start while busy must be ignored.
        run_op(MD_DIV, 32'd100, 32'd7, 3, 0, lat, res, b1, bk);
        check("poke_res",  res,         32'd14);
        check("poke_lat",  32'(lat),    32'd34);

        // Asynchronous reset in cycle 5 of a divide.
        func3 = MD_DIV; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_busy",   32'(busy),  32'h0);
        check("arst_done",   32'(done),  32'h0);
        check("arst_result", result,     32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(MD_MUL, 32'd6, 32'd7, 0, 0, lat, res, b1, bk);
        check("post_rst_mul", res,      32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
